// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Decodes RV32I R-type (0110011) and I-type (0010011) ALU instructions,
// drives an external ALU with registered operands, waits ALU_LAT cycles for
// the result and presents it on a valid/ready response port. Other opcodes
// and bad funct7 encodings are answered one cycle after accept with
// out_illegal set.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    request handshake
//   instr                  RV32I instruction word
//   rs1_val, rs2_val       source register values
//   alu_lhs, alu_rhs       ALU operands (held between accepts)
//   alu_op                 ALU operation code
//   alu_res, alu_flags     ALU result and {ZF,SF,CF,OF}
//   out_valid / out_ready  response handshake
//   out_res, out_flags     response result and flags
//   out_rd                 destination register index
//   out_illegal            instruction was not a legal ALU instruction

module alu_sequencer #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] alu_lhs,
    output logic [31:0] alu_rhs,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_res,
    input  logic [3:0]  alu_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic [3:0]  out_flags,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

    state_t      state;
    state_t      state_next;
    logic [2:0]  lat_cnt;
    logic        accept;
    logic        dec_legal;
    logic [3:0]  dec_op;
    logic [31:0] dec_rhs;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // rs1 index is resolved outside; its value arrives on rs1_val
    assign unused_rs1_field = ^instr[19:15];

    assign accept = in_valid && in_ready;

    // Instruction decode: legality, ALU op and second operand
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 4'b0000;
        dec_rhs   = rs2_val;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_op    = {1'b0, funct3};
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_op    = 4'b1000;
                    end else if (funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_op    = 4'b1001;
                    end
                end
            end
            7'b0010011: begin
                dec_rhs = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    3'b001: begin
                        // shift amount is the unsigned low 5 immediate bits
                        dec_rhs = {27'd0, instr[24:20]};
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_op    = 4'b0001;
                        end
                    end
                    3'b101: begin
                        dec_rhs = {27'd0, instr[24:20]};
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_op    = 4'b0101;
                        end else if (funct7 == 7'b0100000) begin
                            dec_legal = 1'b1;
                            dec_op    = 4'b1001;
                        end
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_op    = {1'b0, funct3};
                    end
                endcase
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an accept from IDLE or RESP takes priority
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = dec_legal ? EXEC : RESP;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                EXEC:    state_next = (lat_cnt == 3'd0) ? RESP : EXEC;
                RESP:    state_next = out_ready ? IDLE : RESP;
                default: state_next = IDLE;
            endcase
        end
    end

    // Handshake outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            EXEC: in_ready = 1'b0;
            RESP: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath: operands captured on legal accept, result captured when the
    // countdown expires. The counter starts at ALU_LAT so EXEC lasts
    // ALU_LAT+1 cycles, giving the ALU its full latency before sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_lhs     <= 32'd0;
            alu_rhs     <= 32'd0;
            alu_op      <= 4'b0000;
            lat_cnt     <= 3'd0;
            out_res     <= 32'd0;
            out_flags   <= 4'b0000;
            out_rd      <= 5'd0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_rd <= instr[11:7];
            if (dec_legal) begin
                alu_lhs     <= rs1_val;
                alu_rhs     <= dec_rhs;
                alu_op      <= dec_op;
                lat_cnt     <= LAT_LOAD;
                out_illegal <= 1'b0;
            end else begin
                out_illegal <= 1'b1;
                out_res     <= 32'd0;
                out_flags   <= 4'b0000;
            end
        end else if (state == EXEC) begin
            if (lat_cnt == 3'd0) begin
                // writes to x0 report a zero result but keep the ALU flags
                out_res   <= (out_rd == 5'd0) ? 32'd0 : alu_res;
                out_flags <= alu_flags;
            end else begin
                lat_cnt <= lat_cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//
// Directed bench for alu_sequencer with ALU_LAT=1. A registered behavioural
// ALU supplies alu_res/alu_flags one cycle after the operands change; all
// expected response values are hand-computed constants. Inputs are driven
// and outputs sampled on the falling clock edge.

module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_lhs;
    logic [31:0] alu_rhs;
    logic [3:0]  alu_op;
    logic [31:0] alu_res;
    logic [3:0]  alu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [3:0]  out_flags;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    alu_sequencer #(.ALU_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .alu_lhs    (alu_lhs),
        .alu_rhs    (alu_rhs),
        .alu_op     (alu_op),
        .alu_res    (alu_res),
        .alu_flags  (alu_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_flags  (out_flags),
        .out_rd     (out_rd),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU returning {ZF,SF,CF,OF, result}; CF on sub is borrow
    function automatic logic [35:0] aluModel(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        o;
        w = 33'd0;
        r = 32'd0;
        c = 1'b0;
        o = 1'b0;
        case (op)
            4'b0000: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b1000: begin
                r = a - b;
                c = (a < b);
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0001: r = a << b[4:0];
            4'b0010: r = {31'd0, $signed(a) < $signed(b)};
            4'b0011: r = {31'd0, a < b};
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b1001: r = $signed(a) >>> b[4:0];
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r[31], c, o, r};
    endfunction

    always @(posedge clk) begin
        {alu_flags, alu_res} <= aluModel(alu_op, alu_lhs, alu_rhs);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one request; returns on the falling edge after the accept edge
    task automatic applyStimulus(input logic [31:0] i, input logic [31:0] a,
                                 input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        rs1_val  = a;
        rs2_val  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic checkResp(input string tag, input logic [31:0] res,
                             input logic [3:0] flags, input logic [4:0] rd,
                             input logic ill);
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_res"}, out_res, res);
        checkOutput({tag, "_flags"}, {28'd0, out_flags}, {28'd0, flags});
        checkOutput({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
        checkOutput({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, ill});
    endtask

    task automatic popResp(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_pop_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_pop_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'd0;
        rs1_val   = 32'd0;
        rs2_val   = 32'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_illegal", {31'd0, out_illegal}, 32'd0);
        checkOutput("rst_res", out_res, 32'd0);
        checkOutput("rst_flags", {28'd0, out_flags}, 32'd0);
        checkOutput("rst_rd", {27'd0, out_rd}, 32'd0);
        checkOutput("rst_lhs", alu_lhs, 32'd0);
        checkOutput("rst_rhs", alu_rhs, 32'd0);
        checkOutput("rst_op", {28'd0, alu_op}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);

        // add x3,x1,x2 : ffffffff + 1
        applyStimulus(32'h002081B3, 32'hFFFFFFFF, 32'h00000001);
        checkOutput("add_op", {28'd0, alu_op}, 32'h0);
        checkOutput("add_lhs", alu_lhs, 32'hFFFFFFFF);
        checkOutput("add_rhs", alu_rhs, 32'h00000001);
        checkOutput("add_exec_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("add_valid_c0", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("add_valid_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkResp("add", 32'h00000000, 4'b1010, 5'd3, 1'b0);
        popResp("add");

        // sub x4,x1,x2 : signed overflow
        applyStimulus(32'h40208233, 32'h80000000, 32'h0FFFFFFF);
        checkOutput("sub_op", {28'd0, alu_op}, 32'h8);
        checkOutput("sub_rhs", alu_rhs, 32'h0FFFFFFF);
        @(negedge clk);
        checkOutput("sub_valid_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkResp("sub", 32'h70000001, 4'b0001, 5'd4, 1'b0);
        popResp("sub");

        // srai x5,x6,3 : shift amount zero-extended, not 0x403
        applyStimulus(32'h40335293, 32'hFFFFFFFF, 32'h00000000);
        checkOutput("srai_op", {28'd0, alu_op}, 32'h9);
        checkOutput("srai_rhs", alu_rhs, 32'h00000003);
        repeat (2) @(negedge clk);
        checkResp("srai", 32'hFFFFFFFF, 4'b0100, 5'd5, 1'b0);
        popResp("srai");

        // lw x9,0(x1) : illegal, one cycle, ALU outputs untouched
        applyStimulus(32'h0000A483, 32'h12345678, 32'h9ABCDEF0);
        checkResp("load", 32'h0, 4'b0000, 5'd9, 1'b1);
        checkOutput("load_op_held", {28'd0, alu_op}, 32'h9);
        checkOutput("load_rhs_held", alu_rhs, 32'h00000003);
        checkOutput("load_lhs_held", alu_lhs, 32'hFFFFFFFF);
        popResp("load");

        // slli x7,x6,3 with funct7 0100000 : illegal
        applyStimulus(32'h40331393, 32'hFFFFFFFF, 32'h0);
        checkResp("slli_bad", 32'h0, 4'b0000, 5'd7, 1'b1);
        popResp("slli_bad");

        // addi x0,x1,5 : result suppressed, flags kept
        applyStimulus(32'h00508013, 32'hFFFFFFFE, 32'h0);
        checkOutput("addi_x0_op", {28'd0, alu_op}, 32'h0);
        checkOutput("addi_x0_rhs", alu_rhs, 32'h00000005);
        repeat (2) @(negedge clk);
        checkResp("addi_x0", 32'h0, 4'b0010, 5'd0, 1'b0);
        popResp("addi_x0");

        // addi x8,x1,-1 : sign-extended immediate
        applyStimulus(32'hFFF08413, 32'h00000001, 32'h0);
        checkOutput("addi_neg_rhs", alu_rhs, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        checkResp("addi_neg", 32'h0, 4'b1010, 5'd8, 1'b0);
        popResp("addi_neg");

        // R-type xor with funct7 0100000 : illegal
        applyStimulus(32'h4020C533, 32'h1, 32'h2);
        checkResp("xor_bad", 32'h0, 4'b0000, 5'd10, 1'b1);
        popResp("xor_bad");

        // requests offered during EXEC are ignored
        applyStimulus(32'h002081B3, 32'h00000002, 32'h00000003);
        in_valid = 1'b1;
        instr    = 32'h0000A483;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkResp("exec_ign", 32'h00000005, 4'b0000, 5'd3, 1'b0);
        popResp("exec_ign");
        @(negedge clk);
        checkOutput("exec_ign_nodup", {31'd0, out_valid}, 32'd0);

        // back-pressure then zero-bubble accept
        applyStimulus(32'h002081B3, 32'h00000005, 32'h00000007);
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        instr    = 32'h40208233;
        rs1_val  = 32'h80000000;
        rs2_val  = 32'h0FFFFFFF;
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall_res", out_res, 32'h0000000C);
            checkOutput("stall_rd", {27'd0, out_rd}, 32'd3);
            checkOutput("stall_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("b2b_valid_c0", {31'd0, out_valid}, 32'd0);
        checkOutput("b2b_op", {28'd0, alu_op}, 32'h8);
        @(negedge clk);
        checkOutput("b2b_valid_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkResp("b2b", 32'h70000001, 4'b0001, 5'd4, 1'b0);
        popResp("b2b");

        // reset pulse during EXEC discards the instruction
        applyStimulus(32'h002081B3, 32'h00000001, 32'h00000001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("mid_rst_op", {28'd0, alu_op}, 32'h0);
        checkOutput("mid_rst_lhs", alu_lhs, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("mid_rst_noresp", {31'd0, out_valid}, 32'd0);
        applyStimulus(32'h002081B3, 32'h00000001, 32'h00000001);
        repeat (2) @(negedge clk);
        checkResp("post_rst", 32'h00000002, 4'b0000, 5'd3, 1'b0);
        popResp("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter ALU_LAT, default 1: ALU result latency in clk cycles after operands/op are presented (legal 1..7).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  instruction request valid.
REQ-005 in_ready  out  1  sequencer can accept a request.
REQ-006 instr  in  32  RV32I instruction word.
REQ-007 rs1_val, rs2_val  in  32 each  source register values.
REQ-008 alu_lhs, alu_rhs  out  32 each  ALU operands.
REQ-009 alu_op  out  4  ALU op code.
REQ-010 alu_res  in  32  ALU result; alu_flags  in  4  {ZF,SF,CF,OF}.
REQ-011 out_valid  out  1; out_ready  in  1  response handshake.
REQ-012 out_res  out  32; out_flags  out  4 {ZF,SF,CF,OF}; out_rd  out  5; out_illegal  out  1.

Function
REQ-013 FSM states IDLE, EXEC, RESP; transfer occurs on any edge where valid and ready are both high.
REQ-014 in_ready = 1 in IDLE; = out_ready in RESP; = 0 in EXEC.
REQ-015 Legal opcodes: 0110011 (R-type), 0010011 (I-type); all others illegal.
REQ-016 alu_op map: add/addi 0000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, or 0110, and 0111, sub 1000, sra 1001; 1010/1011 never issued.
REQ-017 R-type: funct7 0100000 legal only with funct3 000 (sub) or 101 (sra); funct7 0000000 legal for all funct3; other funct7 illegal.
REQ-018 I-type: alu_rhs = sign-extended instr[31:20]; shifts use zero-extended instr[24:20], slli requires instr[31:25]=0000000, srli/srai require 0000000/0100000, else illegal.
REQ-019 alu_lhs = rs1_val; R-type alu_rhs = rs2_val; alu_lhs/rhs/op registered at accept edge and held stable until the next accept.
REQ-020 Legal accept: IDLE/RESP -> EXEC, counter loaded; sequencer samples alu_res/alu_flags on the edge ALU_LAT+1 cycles after accept, then -> RESP; out_valid rises ALU_LAT+1 cycles after accept.
REQ-021 Illegal accept: -> RESP next edge, ALU outputs unchanged, out_illegal=1, out_res=0, out_flags=0, out_rd=instr[11:7].
REQ-022 out_rd = instr[11:7]; if rd=0 on a legal instruction, out_res=0 while out_flags still pass ALU flags.
REQ-023 RESP: out_valid held with out_res/out_flags/out_rd/out_illegal stable until out_ready=1.
REQ-024 RESP with out_ready=1 and in_valid=0 -> IDLE; with in_valid=1 new request accepted same edge (-> EXEC or RESP), zero bubble.
REQ-025 in_valid/instr changes during EXEC are ignored; no request is lost or duplicated.

Reset
REQ-026 rst high at an edge -> IDLE, out_valid=0, out_illegal=0, out_res=0, out_flags=0, out_rd=0, alu_lhs=0, alu_rhs=0, alu_op=0000, counter=0.
REQ-027 rst mid-EXEC or mid-RESP discards the in-flight instruction; no response is produced for it.
REQ-028 in_ready=1 on the first cycle after rst deasserts.

Verification
REQ-029 add x3,x1,x2, rs1=ffffffff, rs2=00000001, ALU_LAT=1 -> alu_op 0000; out_valid 2 cycles after accept; out_res 00000000, out_flags 1010, out_rd 3.
REQ-030 sub x4,x1,x2, rs1=80000000, rs2=0fffffff -> alu_op 1000; out_res 70000001, out_flags[0] (OF)=1.
REQ-031 srai x5,x6,3, rs1=ffffffff -> alu_op 1001, alu_rhs 00000003, out_res ffffffff; slli with instr[31:25]=0100000 -> out_illegal=1, out_res 0, 1 cycle latency.
REQ-032 addi x0,x1,5 -> alu_rhs 00000005, out_res 00000000, out_rd 0; load opcode 0000011 -> out_illegal=1, alu_op unchanged.
REQ-033 out_ready low 5 cycles in RESP -> out_* stable, in_ready=0; then out_ready=1 with in_valid=1 -> new request accepted same edge, next result ALU_LAT+1 cycles later.
REQ-034 rst pulsed 1 cycle in EXEC -> IDLE next cycle, out_valid stays 0, in_ready=1; following add completes normally.
